// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Exhaustive stimulus generator and checker for a small single-output
// combinational block. Every one of the 2^N_IN input vectors is applied to the
// block under test and held for HOLD cycles. The block's output is sampled on
// the last cycle of each hold and compared with the expected truth table
// EXPECT. The mismatch count, the first failing vector and a pass flag are
// reported.
//
// Parameters:
//   N_IN    DUT input width (1..8)
//   HOLD    cycles each vector is held (>= 1)
//   EXPECT  expected truth table, bit k = expected output for vector value k
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   start            in   begin a sweep (honoured in IDLE or DONE only)
//   vec_out          out  N_IN-bit vector driven to the DUT, MSB toggles slowest
//   dut_y            in   DUT output under test
//   busy             out  high while a sweep is running
//   done             out  one-cycle pulse at the end of a sweep
//   pass             out  last sweep finished with zero mismatches
//   err_cnt          out  N_IN+1-bit mismatch count of current/last sweep
//   first_err_vec    out  vector value of the first mismatch
//   first_err_valid  out  at least one mismatch seen in this sweep
//
// Build option:
//   SWEEP_GRAY_EN    when defined, vectors are applied in Gray-code order so
//                    exactly one DUT input changes per step; otherwise plain
//                    binary order is used.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int                     N_IN   = 3,
  parameter int                     HOLD   = 4,
  parameter logic [(2**N_IN)-1:0]   EXPECT = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  // HOLD=1 still needs a one-bit counter so the register is never zero-width.
  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;
  localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N_IN:0]   errCnt_q, errCnt_d;
  logic [N_IN-1:0] firstVec_q, firstVec_d;
  logic            firstValid_q, firstValid_d;
  logic            pass_q, pass_d;
  logic            expY;
  logic            mismatch;

  // The applied vector is derived from the step index, so it naturally holds
  // its last value once the index stops moving in DONE and IDLE.
`ifdef SWEEP_GRAY_EN
  assign vec_out = idx_q ^ (idx_q >> 1);
`else
  assign vec_out = idx_q;
`endif

  // The truth table is indexed by the vector value, not by the step number,
  // so Gray ordering does not change what is expected.
  assign expY     = EXPECT[vec_out];
  assign mismatch = (dut_y != expY);

  // Next-state logic: starting a sweep clears every result register on the
  // same edge; in RUN the hold counter gates the sample, and the last
  // sample's mismatch is folded into the pass decision.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    errCnt_d     = errCnt_q;
    firstVec_d   = firstVec_q;
    firstValid_d = firstValid_q;
    pass_d       = pass_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          idx_d        = '0;
          hold_d       = '0;
          errCnt_d     = '0;
          firstVec_d   = '0;
          firstValid_d = 1'b0;
          pass_d       = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (mismatch) begin
            errCnt_d = errCnt_q + ERR_ONE;
            if (!firstValid_q) begin
              firstVec_d   = vec_out;
              firstValid_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            pass_d  = (errCnt_d == '0);
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset wins over a simultaneous start and
  // suppresses any pending done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      errCnt_q     <= '0;
      firstVec_q   <= '0;
      firstValid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      errCnt_q     <= errCnt_d;
      firstVec_q   <= firstVec_d;
      firstValid_q <= firstValid_d;
      pass_q       <= pass_d;
    end
  end

  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign err_cnt         = errCnt_q;
  assign first_err_vec   = firstVec_q;
  assign first_err_valid = firstValid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// Testbench for truth_table_sweeper.
//
// Three instances share clock, reset and start:
//   dut1  N_IN=3 HOLD=4 EXPECT=E8, output selectable (majority, tied 0,
//         noisy majority, random) and compared every cycle with a model
//   dut2  N_IN=1 HOLD=2 EXPECT=01 driven by an inverter
//   dut3  N_IN=3 HOLD=1 EXPECT=E8 driven by a majority gate
// Directed sweeps pin literal results, then a randomized phase exercises
// start/reset/noise against the model.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  localparam int H1     = 4;
  localparam int TOTAL1 = 32;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  logic [2:0] vecOut1;
  logic       dutY1, busy1, done1, pass1, firstValid1;
  logic [3:0] errCnt1;
  logic [2:0] firstVec1;

  logic       vecOut2;
  logic       dutY2, busy2, done2, pass2, firstValid2;
  logic [1:0] errCnt2;
  logic       firstVec2;

  logic [2:0] vecOut3;
  logic       dutY3, busy3, done3, pass3, firstValid3;
  logic [3:0] errCnt3;
  logic [2:0] firstVec3;

  int   yMode    = 0;
  logic noiseBit = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // DUT output for dut1 depends on the selected behaviour
  always_comb begin
    case (yMode)
      1:       dutY1 = 1'b0;
      2:       dutY1 = maj3(vecOut1) ^ noiseBit;
      3:       dutY1 = noiseBit;
      default: dutY1 = maj3(vecOut1);
    endcase
  end

  assign dutY2 = ~vecOut2;
  assign dutY3 = maj3(vecOut3);

  truth_table_sweeper #(.N_IN(3), .HOLD(H1), .EXPECT(8'hE8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .vec_out(vecOut1), .dut_y(dutY1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(errCnt1),
    .first_err_vec(firstVec1), .first_err_valid(firstValid1)
  );

  truth_table_sweeper #(.N_IN(1), .HOLD(2), .EXPECT(2'b01)) dut2 (
    .clk(clk), .rst(rst), .start(start), .vec_out(vecOut2), .dut_y(dutY2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(errCnt2),
    .first_err_vec(firstVec2), .first_err_valid(firstValid2)
  );

  truth_table_sweeper #(.N_IN(3), .HOLD(1), .EXPECT(8'hE8)) dut3 (
    .clk(clk), .rst(rst), .start(start), .vec_out(vecOut3), .dut_y(dutY3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(errCnt3),
    .first_err_vec(firstVec3), .first_err_valid(firstValid3)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, actual, expected);
    end
  endtask

  // Vector applied at a given step, from the ordering rule
  function automatic int orderVec(input int step);
`ifdef SWEEP_GRAY_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

  // Behavioural model for dut1: a run is a count of elapsed cycles; the
  // vector is step = cycle / HOLD and a sample happens on the last cycle
  // of each hold.
  logic [7:0] expBits = 8'hE8;
  int  mMode       = M_IDLE;
  int  mCycle      = 0;
  int  mErr        = 0;
  int  mFirstVec   = 0;
  bit  mFirstValid = 1'b0;
  bit  mPass       = 1'b0;
  int  mVec        = 0;
  bit  modelValid  = 1'b0;

  // Compare on the falling edge, then advance the model to what the next
  // rising edge will produce using the inputs currently presented.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("busy", 32'(busy1), 32'(mMode == M_RUN));
      checkOutput("done", 32'(done1), 32'(mMode == M_DONE));
      checkOutput("pass", 32'(pass1), 32'(mPass));
      checkOutput("err_cnt", 32'(errCnt1), 32'(mErr));
      checkOutput("first_err_vec", 32'(firstVec1), 32'(mFirstVec));
      checkOutput("first_err_valid", 32'(firstValid1), 32'(mFirstValid));
      checkOutput("vec_out", 32'(vecOut1), 32'(mVec));
    end
    if (rst) begin
      mMode = M_IDLE; mCycle = 0; mErr = 0; mFirstVec = 0;
      mFirstValid = 1'b0; mPass = 1'b0; mVec = 0;
      modelValid = 1'b1;
    end else if (mMode == M_RUN) begin
      if (mCycle % H1 == H1 - 1) begin
        if (dutY1 !== expBits[mVec[2:0]]) begin
          mErr++;
          if (!mFirstValid) begin
            mFirstValid = 1'b1;
            mFirstVec   = mVec;
          end
        end
      end
      mCycle++;
      if (mCycle == TOTAL1) begin
        mMode = M_DONE;
        mPass = (mErr == 0);
      end else begin
        mVec = orderVec(mCycle / H1);
      end
    end else begin
      if (start) begin
        mMode = M_RUN; mCycle = 0; mErr = 0; mFirstVec = 0;
        mFirstValid = 1'b0; mPass = 1'b0; mVec = 0;
      end else if (mMode == M_DONE) begin
        mMode = M_IDLE;
      end
    end
  end

  // Results captured during a directed sweep
  int         doneAt1, doneAt2, doneAt3;
  logic       passAt1, fvalidAt1, passAt2, fvalidAt2, fvAt2, passAt3, fvalidAt3;
  logic [3:0] errAt1, errAt3;
  logic [1:0] errAt2;
  logic [2:0] fvAt1, fvAt3;
  logic [2:0] seq3 [8];
  int         seqLen;

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy1), 32'd0);
    checkOutput({tag, "_done"}, 32'(done1), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass1), 32'd0);
    checkOutput({tag, "_err_cnt"}, 32'(errCnt1), 32'd0);
    checkOutput({tag, "_first_err_vec"}, 32'(firstVec1), 32'd0);
    checkOutput({tag, "_first_err_valid"}, 32'(firstValid1), 32'd0);
    checkOutput({tag, "_vec_out"}, 32'(vecOut1), 32'd0);
  endtask

  // Pulse (or hold) start so that it is sampled at edge E0, then watch all
  // three instances for a bounded number of cycles after E0.
  task automatic applyStimulus(input bit holdStart, input int rstAt, input int cycles);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1;
    doneAt1 = -1; doneAt2 = -1; doneAt3 = -1; seqLen = 0;
    if (busy3) begin
      seq3[0] = vecOut3;
      seqLen  = 1;
    end
    #1 if (!holdStart) start = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      if (done1 && doneAt1 < 0) begin
        doneAt1 = k; passAt1 = pass1; errAt1 = errCnt1;
        fvAt1 = firstVec1; fvalidAt1 = firstValid1;
      end
      if (done2 && doneAt2 < 0) begin
        doneAt2 = k; passAt2 = pass2; errAt2 = errCnt2;
        fvAt2 = firstVec2; fvalidAt2 = firstValid2;
      end
      if (done3 && doneAt3 < 0) begin
        doneAt3 = k; passAt3 = pass3; errAt3 = errCnt3;
        fvAt3 = firstVec3; fvalidAt3 = firstValid3;
      end
      if (busy3 && seqLen < 8) begin
        seq3[seqLen] = vecOut3;
        seqLen++;
      end
      if (k == rstAt) checkReset("midReset");
      if (holdStart && doneAt1 > 0 && k == doneAt1 + 1) begin
        checkOutput("restart_busy", 32'(busy1), 32'd1);
        checkOutput("restart_vec_out", 32'(vecOut1), 32'd0);
      end
      #1;
      rst = (k == rstAt - 1);
      if (holdStart && doneAt1 > 0 && k >= doneAt1 + 1) start = 1'b0;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  logic [2:0] seqRef [8];

  initial begin
`ifdef SWEEP_GRAY_EN
    seqRef = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
    seqRef = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    $display("[TB] truth_table_sweeper bench starting");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkReset("reset");
    #1 rst = 1'b0;

    // Majority DUT on every instance: clean sweeps
    yMode = 0;
    applyStimulus(1'b0, -1, 40);
    checkOutput("majority_done_at", 32'(doneAt1), 32'd32);
    checkOutput("majority_pass", 32'(passAt1), 32'd1);
    checkOutput("majority_err_cnt", 32'(errAt1), 32'd0);
    checkOutput("majority_first_err_valid", 32'(fvalidAt1), 32'd0);
    checkOutput("n1_done_at", 32'(doneAt2), 32'd4);
    checkOutput("n1_pass", 32'(passAt2), 32'd1);
    checkOutput("n1_err_cnt", 32'(errAt2), 32'd0);
    checkOutput("n1_first_err_valid", 32'(fvalidAt2), 32'd0);
    checkOutput("n1_first_err_vec", 32'(fvAt2), 32'd0);
    checkOutput("hold1_done_at", 32'(doneAt3), 32'd8);
    checkOutput("hold1_pass", 32'(passAt3), 32'd1);
    checkOutput("hold1_err_cnt", 32'(errAt3), 32'd0);
    checkOutput("hold1_first_err_valid", 32'(fvalidAt3), 32'd0);
    checkOutput("hold1_first_err_vec", 32'(fvAt3), 32'd0);
    checkOutput("hold1_seq_len", 32'(seqLen), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("hold1_seq_%0d", i), 32'(seq3[i]), 32'(seqRef[i]));
`ifdef SWEEP_GRAY_EN
      if (i > 0)
        checkOutput($sformatf("gray_hamming_%0d", i), 32'($countones(seq3[i] ^ seq3[i-1])), 32'd1);
`endif
    end

    // Reset ten cycles into a sweep, then a clean sweep
    applyStimulus(1'b0, 10, 60);
    checkOutput("reset_no_done", 32'(doneAt1), 32'hFFFF_FFFF);
    applyStimulus(1'b0, -1, 40);
    checkOutput("after_reset_done_at", 32'(doneAt1), 32'd32);
    checkOutput("after_reset_pass", 32'(passAt1), 32'd1);

    // Output tied low: majority expects 1 for 3,5,6,7
    yMode = 1;
    applyStimulus(1'b0, -1, 40);
    checkOutput("tied0_done_at", 32'(doneAt1), 32'd32);
    checkOutput("tied0_err_cnt", 32'(errAt1), 32'd4);
    checkOutput("tied0_first_err_vec", 32'(fvAt1), 32'd3);
    checkOutput("tied0_first_err_valid", 32'(fvalidAt1), 32'd1);
    checkOutput("tied0_pass", 32'(passAt1), 32'd0);
    checkOutput("model_tied0_err", 32'(mErr), 32'd4);
    checkOutput("model_tied0_first_vec", 32'(mFirstVec), 32'd3);
    yMode = 0;

    // start held through the whole sweep and into DONE
    applyStimulus(1'b1, -1, 75);
    checkOutput("held_start_done_at", 32'(doneAt1), 32'd32);
    checkOutput("held_start_pass", 32'(passAt1), 32'd1);

    // Randomized phase checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (c % 64 == 0) yMode = $urandom_range(0, 3);
      noiseBit = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 299) == 0);
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
